// File: rtl/tlb_op_ctrl_if.sv
// Request/response handshake between the WB-stage TLB-instruction logic and tlb_op_ctrl.
// master = instruction/CSR side, slave = the controller.
interface tlb_op_ctrl_if #(
  parameter int IDXW = 4
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [4:0]      req_inv_op;
  logic [9:0]      req_inv_asid;
  logic [31:0]     req_inv_va;

  logic            resp_valid;
  logic            resp_ready;
  logic            resp_err;
  logic            resp_found;
  logic [IDXW-1:0] resp_idx;
  logic            resp_e;
  logic [5:0]      resp_ps;
  logic [18:0]     resp_vppn;
  logic [9:0]      resp_asid;
  logic [31:0]     resp_elo0;
  logic [31:0]     resp_elo1;

  modport master (
    output req_valid, req_op, req_inv_op, req_inv_asid, req_inv_va, resp_ready,
    input  req_ready, resp_valid, resp_err, resp_found, resp_idx, resp_e,
           resp_ps, resp_vppn, resp_asid, resp_elo0, resp_elo1
  );

  modport slave (
    input  req_valid, req_op, req_inv_op, req_inv_asid, req_inv_va, resp_ready,
    output req_ready, resp_valid, resp_err, resp_found, resp_idx, resp_e,
           resp_ps, resp_vppn, resp_asid, resp_elo0, resp_elo1
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB against the TLB and returns CSR results.
//   state  | meaning
//   IDLE   | ready for an op; operands and CSRs latched on accept
//   SRCH   | drive port 1 with latched VPPN/ASID, capture hit/index
//   RD     | drive read index, capture entry into TLBELO layout
//   WR     | one-cycle write strobe (TLBWR index or FILL counter)
//   INV    | one-cycle invtlb strobe when op code is legal
//   RESP   | hold result until resp_ready
module tlb_op_ctrl #(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            resetn,
  tlb_op_ctrl_if.slave    bus,
  input  logic [IDXW-1:0] csr_idx,
  input  logic [5:0]      csr_ps,
  input  logic            csr_ne,
  input  logic [18:0]     csr_vppn,
  input  logic [9:0]      csr_asid,
  input  logic [31:0]     csr_elo0,
  input  logic [31:0]     csr_elo1,
  input  logic            csr_tlbr,
  output logic [18:0]     tlb_s_vppn,
  output logic            tlb_s_va_bit12,
  output logic [9:0]      tlb_s_asid,
  input  logic            tlb_s_found,
  input  logic [IDXW-1:0] tlb_s_index,
  output logic [IDXW-1:0] tlb_r_index,
  input  logic [35:0]     tlb_r_hi,
  input  logic            tlb_r_g,
  input  logic [25:0]     tlb_r_lo0,
  input  logic [25:0]     tlb_r_lo1,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic [35:0]     tlb_w_hi,
  output logic            tlb_w_g,
  output logic [25:0]     tlb_w_lo0,
  output logic [25:0]     tlb_w_lo1,
  output logic            tlb_inv_valid,
  output logic [4:0]      tlb_inv_op
);

  typedef enum logic [2:0] {S_IDLE, S_SRCH, S_RD, S_WR, S_INV, S_RESP} state_t;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  state_t          state_q, state_d;
  logic            accept;
  logic            inv_legal;
  logic            w_e;

  logic [2:0]      op_q;
  logic [4:0]      inv_op_q;
  logic [9:0]      inv_asid_q;
  logic [19:0]     inv_va_q;
  logic [IDXW-1:0] idx_q, fill_q, fill_cnt;
  logic [5:0]      ps_q;
  logic            ne_q, tlbr_q, g_q;
  logic [18:0]     vppn_q;
  logic [9:0]      asid_q;
  logic [25:0]     lo0_q, lo1_q;

  logic            resp_err_q, resp_found_q, resp_e_q;
  logic [IDXW-1:0] resp_idx_q;
  logic [5:0]      resp_ps_q;
  logic [18:0]     resp_vppn_q;
  logic [9:0]      resp_asid_q;
  logic [31:0]     resp_elo0_q, resp_elo1_q;

  logic            unused_bits;

  // TLB lo word is {ppn, plv, mat, d, v}; CSR word has MAT above PLV and G at bit 6.
  function automatic logic [25:0] elo_to_lo(input logic [31:0] elo);
    return {elo[27:8], elo[3:2], elo[5:4], elo[1], elo[0]};
  endfunction

  function automatic logic [31:0] lo_to_elo(input logic [25:0] lo, input logic g);
    return {4'b0, lo[25:6], 1'b0, g, lo[3:2], lo[5:4], lo[1], lo[0]};
  endfunction

  assign accept      = (state_q == S_IDLE) && bus.req_valid;
  assign inv_legal   = (inv_op_q <= 5'd6);
  assign w_e         = tlbr_q ? 1'b1 : ~ne_q;
  assign unused_bits = ^{csr_elo0[31:28], csr_elo0[7], csr_elo1[31:28], csr_elo1[7],
                         bus.req_inv_va[11:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    tlb_s_vppn     = '0;
    tlb_s_va_bit12 = 1'b0;
    tlb_s_asid     = '0;
    tlb_r_index    = '0;
    tlb_we         = 1'b0;
    tlb_w_index    = '0;
    tlb_w_hi       = '0;
    tlb_w_g        = 1'b0;
    tlb_w_lo0      = '0;
    tlb_w_lo1      = '0;
    tlb_inv_valid  = 1'b0;
    tlb_inv_op     = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          case (bus.req_op)
            OP_SRCH:         state_d = S_SRCH;
            OP_RD:           state_d = S_RD;
            OP_WR, OP_FILL:  state_d = S_WR;
            OP_INV:          state_d = S_INV;
            default:         state_d = S_RESP;
          endcase
        end
      end
      S_SRCH: begin
        tlb_s_vppn = vppn_q;
        tlb_s_asid = asid_q;
        state_d    = S_RESP;
      end
      S_RD: begin
        tlb_r_index = idx_q;
        state_d     = S_RESP;
      end
      S_WR: begin
        tlb_we      = 1'b1;
        tlb_w_index = (op_q == OP_FILL) ? fill_q : idx_q;
        tlb_w_hi    = {w_e, vppn_q, ps_q, asid_q};
        tlb_w_g     = g_q;
        tlb_w_lo0   = lo0_q;
        tlb_w_lo1   = lo1_q;
        state_d     = S_RESP;
      end
      S_INV: begin
        if (inv_legal) begin
          tlb_inv_valid  = 1'b1;
          tlb_inv_op     = inv_op_q;
          tlb_s_asid     = inv_asid_q;
          tlb_s_vppn     = inv_va_q[19:1];
          tlb_s_va_bit12 = inv_va_q[0];
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                              fill_cnt <= '0;
    else if (fill_cnt == IDXW'(TLBNUM - 1))   fill_cnt <= '0;
    else                                      fill_cnt <= fill_cnt + 1'b1;
  end

  // Snapshot everything at accept so CSR writes during the op cannot leak in.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q       <= '0;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_va_q   <= '0;
      idx_q      <= '0;
      fill_q     <= '0;
      ps_q       <= '0;
      ne_q       <= 1'b0;
      tlbr_q     <= 1'b0;
      g_q        <= 1'b0;
      vppn_q     <= '0;
      asid_q     <= '0;
      lo0_q      <= '0;
      lo1_q      <= '0;
    end else if (accept) begin
      op_q       <= bus.req_op;
      inv_op_q   <= bus.req_inv_op;
      inv_asid_q <= bus.req_inv_asid;
      inv_va_q   <= bus.req_inv_va[31:12];
      idx_q      <= csr_idx;
      fill_q     <= fill_cnt;
      ps_q       <= csr_ps;
      ne_q       <= csr_ne;
      tlbr_q     <= csr_tlbr;
      g_q        <= csr_elo0[6] & csr_elo1[6];
      vppn_q     <= csr_vppn;
      asid_q     <= csr_asid;
      lo0_q      <= elo_to_lo(csr_elo0);
      lo1_q      <= elo_to_lo(csr_elo1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_err_q   <= 1'b0;
      resp_found_q <= 1'b0;
      resp_idx_q   <= '0;
      resp_e_q     <= 1'b0;
      resp_ps_q    <= '0;
      resp_vppn_q  <= '0;
      resp_asid_q  <= '0;
      resp_elo0_q  <= '0;
      resp_elo1_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            resp_err_q   <= (bus.req_op > OP_INV);
            resp_found_q <= 1'b0;
            resp_idx_q   <= '0;
            resp_e_q     <= 1'b0;
            resp_ps_q    <= '0;
            resp_vppn_q  <= '0;
            resp_asid_q  <= '0;
            resp_elo0_q  <= '0;
            resp_elo1_q  <= '0;
          end
        end
        S_SRCH: begin
          resp_found_q <= tlb_s_found;
          resp_idx_q   <= tlb_s_found ? tlb_s_index : '0;
        end
        S_RD: begin
          if (tlb_r_hi[35]) begin
            resp_e_q    <= 1'b1;
            resp_vppn_q <= tlb_r_hi[34:16];
            resp_ps_q   <= tlb_r_hi[15:10];
            resp_asid_q <= tlb_r_hi[9:0];
            resp_elo0_q <= lo_to_elo(tlb_r_lo0, tlb_r_g);
            resp_elo1_q <= lo_to_elo(tlb_r_lo1, tlb_r_g);
          end
        end
        S_INV: begin
          if (!inv_legal) resp_err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_found = resp_found_q;
  assign bus.resp_idx   = resp_idx_q;
  assign bus.resp_e     = resp_e_q;
  assign bus.resp_ps    = resp_ps_q;
  assign bus.resp_vppn  = resp_vppn_q;
  assign bus.resp_asid  = resp_asid_q;
  assign bus.resp_elo0  = resp_elo0_q;
  assign bus.resp_elo1  = resp_elo1_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: expected responses queued at request time, compared when RESP appears.
module tb_tlb_op_ctrl;

  logic        clk;
  logic        resetn;
  logic [3:0]  csr_idx;
  logic [5:0]  csr_ps;
  logic        csr_ne;
  logic [18:0] csr_vppn;
  logic [9:0]  csr_asid;
  logic [31:0] csr_elo0, csr_elo1;
  logic        csr_tlbr;
  logic [18:0] tlb_s_vppn;
  logic        tlb_s_va_bit12;
  logic [9:0]  tlb_s_asid;
  logic        tlb_s_found;
  logic [3:0]  tlb_s_index;
  logic [3:0]  tlb_r_index;
  logic [35:0] tlb_r_hi;
  logic        tlb_r_g;
  logic [25:0] tlb_r_lo0, tlb_r_lo1;
  logic        tlb_we;
  logic [3:0]  tlb_w_index;
  logic [35:0] tlb_w_hi;
  logic        tlb_w_g;
  logic [25:0] tlb_w_lo0, tlb_w_lo1;
  logic        tlb_inv_valid;
  logic [4:0]  tlb_inv_op;

  tlb_op_ctrl_if #(.IDXW(4)) bus ();

  tlb_op_ctrl dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .csr_idx(csr_idx), .csr_ps(csr_ps), .csr_ne(csr_ne), .csr_vppn(csr_vppn),
    .csr_asid(csr_asid), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1), .csr_tlbr(csr_tlbr),
    .tlb_s_vppn(tlb_s_vppn), .tlb_s_va_bit12(tlb_s_va_bit12), .tlb_s_asid(tlb_s_asid),
    .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index),
    .tlb_r_index(tlb_r_index), .tlb_r_hi(tlb_r_hi), .tlb_r_g(tlb_r_g),
    .tlb_r_lo0(tlb_r_lo0), .tlb_r_lo1(tlb_r_lo1),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_hi(tlb_w_hi), .tlb_w_g(tlb_w_g),
    .tlb_w_lo0(tlb_w_lo0), .tlb_w_lo1(tlb_w_lo1),
    .tlb_inv_valid(tlb_inv_valid), .tlb_inv_op(tlb_inv_op)
  );

  typedef struct packed {
    logic        err;
    logic        found;
    logic [3:0]  idx;
    logic        e;
    logic [5:0]  ps;
    logic [18:0] vppn;
    logic [9:0]  asid;
    logic [31:0] elo0;
    logic [31:0] elo1;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  logic [3:0] m_fill;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference fill counter: 4-bit counter wraps 15 -> 0 naturally.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_fill <= 4'd0;
    else         m_fill <= m_fill + 4'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_resp(input string t, input exp_t ex);
    chk({t, ".err"},   64'(bus.resp_err),   64'(ex.err));
    chk({t, ".found"}, 64'(bus.resp_found), 64'(ex.found));
    chk({t, ".idx"},   64'(bus.resp_idx),   64'(ex.idx));
    chk({t, ".e"},     64'(bus.resp_e),     64'(ex.e));
    chk({t, ".ps"},    64'(bus.resp_ps),    64'(ex.ps));
    chk({t, ".vppn"},  64'(bus.resp_vppn),  64'(ex.vppn));
    chk({t, ".asid"},  64'(bus.resp_asid),  64'(ex.asid));
    chk({t, ".elo0"},  64'(bus.resp_elo0),  64'(ex.elo0));
    chk({t, ".elo1"},  64'(bus.resp_elo1),  64'(ex.elo1));
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the execute cycle.
  task automatic accept(input string t, input exp_t ex, input bit push);
    chk({t, ".req_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    if (push) sb.push_back(ex);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic finish(input string t, input bit adv, input int stall);
    exp_t ex;
    int   n;
    if (adv) @(negedge clk);
    chk({t, ".lat"},     64'(bus.resp_valid),  64'd1);
    chk({t, ".we_off"},  64'(tlb_we),          64'd0);
    chk({t, ".inv_off"}, 64'(tlb_inv_valid),   64'd0);
    n = 0;
    while (!bus.resp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!bus.resp_valid) begin
      chk({t, ".timeout"}, 64'(bus.resp_valid), 64'd1);
      return;
    end
    chk({t, ".sb_has"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() == 0) return;
    ex = sb.pop_front();
    for (int i = 0; i < stall; i++) begin
      bus.resp_ready = 1'b0;
      cmp_resp({t, ".hold"}, ex);
      chk({t, ".hold_rdy"}, 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      chk({t, ".hold_vld"}, 64'(bus.resp_valid), 64'd1);
    end
    cmp_resp(t, ex);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk({t, ".done_vld"}, 64'(bus.resp_valid), 64'd0);
    chk({t, ".done_rdy"}, 64'(bus.req_ready),  64'd1);
  endtask

  initial begin
    exp_t ex;
    int   guard;
    bus.req_valid = 0; bus.req_op = 0; bus.req_inv_op = 0; bus.req_inv_asid = 0;
    bus.req_inv_va = 0; bus.resp_ready = 0;
    csr_idx = 0; csr_ps = 0; csr_ne = 0; csr_vppn = 0; csr_asid = 0;
    csr_elo0 = 0; csr_elo1 = 0; csr_tlbr = 0;
    tlb_s_found = 0; tlb_s_index = 0; tlb_r_hi = 0; tlb_r_g = 0; tlb_r_lo0 = 0; tlb_r_lo1 = 0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.req_ready", 64'(bus.req_ready),  64'd1);
    chk("rst.resp_vld",  64'(bus.resp_valid), 64'd0);
    chk("rst.we",        64'(tlb_we),         64'd0);
    chk("rst.inv",       64'(tlb_inv_valid),  64'd0);
    chk("rst.err",       64'(bus.resp_err),   64'd0);
    chk("rst.elo0",      64'(bus.resp_elo0),  64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // TLBWR; CSRs changed after accept must be ignored
    bus.req_op = 3'd2; csr_idx = 4'd5; csr_vppn = 19'h1234; csr_ps = 6'd12; csr_ne = 1'b0;
    csr_asid = 10'h2A; csr_elo0 = 32'h0ABCDE5F; csr_elo1 = 32'h01357961; csr_tlbr = 1'b0;
    ex = '0;
    accept("wr", ex, 1'b1);
    csr_idx = 4'd7; csr_vppn = 19'h7FFFF; csr_ne = 1'b1;
    chk("wr.we",    64'(tlb_we),      64'd1);
    chk("wr.idx",   64'(tlb_w_index), 64'd5);
    chk("wr.hi",    64'(tlb_w_hi),    64'({1'b1, 19'h1234, 6'd12, 10'h2A}));
    chk("wr.g",     64'(tlb_w_g),     64'd1);
    chk("wr.lo0",   64'(tlb_w_lo0),   64'({20'hABCDE, 2'b11, 2'b01, 1'b1, 1'b1}));
    chk("wr.lo1",   64'(tlb_w_lo1),   64'({20'h13579, 2'b00, 2'b10, 1'b0, 1'b1}));
    chk("wr.inv",   64'(tlb_inv_valid), 64'd0);
    finish("wr", 1'b1, 0);

    // TLBSRCH hit
    bus.req_op = 3'd0; csr_vppn = 19'h5555; csr_asid = 10'h155;
    tlb_s_found = 1'b1; tlb_s_index = 4'd9;
    ex = '0; ex.found = 1'b1; ex.idx = 4'd9;
    accept("srch", ex, 1'b1);
    chk("srch.vppn", 64'(tlb_s_vppn),     64'h5555);
    chk("srch.asid", 64'(tlb_s_asid),     64'h155);
    chk("srch.b12",  64'(tlb_s_va_bit12), 64'd0);
    chk("srch.we",   64'(tlb_we),         64'd0);
    finish("srch", 1'b1, 0);

    // TLBSRCH miss with garbage index
    tlb_s_found = 1'b0; tlb_s_index = 4'd6;
    ex = '0;
    accept("miss", ex, 1'b1);
    finish("miss", 1'b1, 0);

    // TLBRD valid entry, response held 4 cycles
    bus.req_op = 3'd1; csr_idx = 4'd3;
    tlb_r_hi  = {1'b1, 19'h70F0F, 6'd21, 10'h3C3}; tlb_r_g = 1'b1;
    tlb_r_lo0 = {20'h12345, 2'b10, 2'b01, 1'b0, 1'b1};
    tlb_r_lo1 = {20'hFEDCB, 2'b01, 2'b11, 1'b1, 1'b0};
    ex = '0; ex.e = 1'b1; ex.vppn = 19'h70F0F; ex.ps = 6'd21; ex.asid = 10'h3C3;
    ex.elo0 = {4'h0, 20'h12345, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 1'b1};
    ex.elo1 = {4'h0, 20'hFEDCB, 1'b0, 1'b1, 2'b11, 2'b01, 1'b1, 1'b0};
    accept("rd", ex, 1'b1);
    chk("rd.ridx", 64'(tlb_r_index), 64'd3);
    finish("rd", 1'b1, 4);

    // TLBRD invalid entry
    tlb_r_hi[35] = 1'b0;
    ex = '0;
    accept("rd0", ex, 1'b1);
    finish("rd0", 1'b1, 0);

    // TLBFILL accepted with counter at 15; TLBR forces E=1 despite NE
    guard = 0;
    while (m_fill != 4'd15 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    bus.req_op = 3'd3; csr_idx = 4'd2; csr_ne = 1'b1; csr_tlbr = 1'b1;
    csr_vppn = 19'h00ABC; csr_ps = 6'd21; csr_asid = 10'h011;
    csr_elo0 = 32'h0ABCDE5F; csr_elo1 = 32'h01357921;
    ex = '0;
    accept("fill", ex, 1'b1);
    chk("fill.we",  64'(tlb_we),      64'd1);
    chk("fill.idx", 64'(tlb_w_index), 64'd15);
    chk("fill.hi",  64'(tlb_w_hi),    64'({1'b1, 19'h00ABC, 6'd21, 10'h011}));
    chk("fill.g",   64'(tlb_w_g),     64'd0);
    finish("fill", 1'b1, 0);

    // Back-to-back FILL: counter went 15 -> 0 -> 1 -> 2 over accept/exec/handshake
    csr_tlbr = 1'b0;
    accept("fill2", ex, 1'b1);
    chk("fill2.idx", 64'(tlb_w_index), 64'd2);
    chk("fill2.e",   64'(tlb_w_hi[35]), 64'd0);
    finish("fill2", 1'b1, 0);

    // INVTLB op 5
    bus.req_op = 3'd4; bus.req_inv_op = 5'd5; bus.req_inv_asid = 10'h3;
    bus.req_inv_va = 32'h0040_3000;
    ex = '0;
    accept("inv", ex, 1'b1);
    chk("inv.vld",  64'(tlb_inv_valid),  64'd1);
    chk("inv.op",   64'(tlb_inv_op),     64'd5);
    chk("inv.asid", 64'(tlb_s_asid),     64'h3);
    chk("inv.vppn", 64'(tlb_s_vppn),     64'h201);
    chk("inv.b12",  64'(tlb_s_va_bit12), 64'd1);
    chk("inv.we",   64'(tlb_we),         64'd0);
    finish("inv", 1'b1, 0);

    // INVTLB op 7 is rejected
    bus.req_inv_op = 5'd7;
    ex = '0; ex.err = 1'b1;
    accept("inv7", ex, 1'b1);
    chk("inv7.vld", 64'(tlb_inv_valid), 64'd0);
    finish("inv7", 1'b1, 0);

    // Illegal op goes straight to RESP
    bus.req_op = 3'd6;
    ex = '0; ex.err = 1'b1;
    accept("ill", ex, 1'b1);
    finish("ill", 1'b0, 0);

    // Reset during WR: strobe drops at once, no response
    bus.req_op = 3'd2; csr_idx = 4'd4;
    accept("rstwr", ex, 1'b0);
    chk("rstwr.we_pre", 64'(tlb_we), 64'd1);
    #1 resetn = 1'b0;
    #1;
    chk("rstwr.we",   64'(tlb_we),         64'd0);
    chk("rstwr.vld",  64'(bus.resp_valid), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstwr.no_resp", 64'(bus.resp_valid), 64'd0);
      chk("rstwr.no_we",   64'(tlb_we),         64'd0);
    end
    chk("rstwr.err", 64'(bus.resp_err), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
- Initiator side of the TLB maintenance interface: sequences TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB against the 16-entry TLB's port 1, read port, write port and invtlb inputs.
- Sits between the WB-stage CSR/TLB-instruction logic and the TLB.
- Takes one op per req handshake and returns results on a resp handshake for CSR update (TLBIDX, TLBEHI, TLBELO0/1, ASID).

Parameters:
TLBNUM, 16, number of TLB entries; IDXW = $clog2(TLBNUM).

Ports:
clk  in  1  clock; all state updates on posedge
resetn  in  1  asynchronous, active-low reset
req_valid  in  1  op request
req_ready  out  1  high only in IDLE
req_op  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5-7 illegal
req_inv_op  in  5  INVTLB op code
req_inv_asid  in  10  INVTLB asid (rj)
req_inv_va  in  32  INVTLB va (rk)
csr_idx  in  IDXW  TLBIDX.Index
csr_ps  in  6  TLBIDX.PS
csr_ne  in  1  TLBIDX.NE
csr_vppn  in  19  TLBEHI.VPPN
csr_asid  in  10  ASID.ASID
csr_elo0  in  32  TLBELO0: V[0] D[1] PLV[3:2] MAT[5:4] G[6] PPN[27:8]
csr_elo1  in  32  TLBELO1, same layout
csr_tlbr  in  1  ESTAT.Ecode==TLBR
resp_valid  out  1  result valid
resp_ready  in  1  result consumed
resp_err  out  1  illegal op or INVTLB op>6
resp_found  out  1  SRCH hit
resp_idx  out  IDXW  SRCH hit index
resp_e  out  1  RD entry E
resp_ps  out  6  RD PS
resp_vppn  out  19  RD VPPN
resp_asid  out  10  RD ASID
resp_elo0  out  32  RD lo0 in TLBELO layout; G = r_g
resp_elo1  out  32  RD lo1, same
tlb_s_vppn  out  19  port-1 vppn
tlb_s_va_bit12  out  1  port-1 va bit 12
tlb_s_asid  out  10  port-1 asid
tlb_s_found  in  1  port-1 found
tlb_s_index  in  IDXW  port-1 index
tlb_r_index  out  IDXW  read index
tlb_r_hi  in  36  {e, vppn, ps, asid}
tlb_r_g  in  1  read G
tlb_r_lo0  in  26  {ppn, plv, mat, d, v}
tlb_r_lo1  in  26  same
tlb_we  out  1  write strobe
tlb_w_index  out  IDXW  write index
tlb_w_hi  out  36  {e, vppn, ps, asid}
tlb_w_g  out  1  elo0.G & elo1.G
tlb_w_lo0  out  26  from csr_elo0
tlb_w_lo1  out  26  from csr_elo1
tlb_inv_valid  out  1  invtlb strobe
tlb_inv_op  out  5  invtlb op

Behaviour:
- Reset (async, resetn=0):
  - State IDLE; fill_cnt=0.
  - All resp_* outputs and every latched operand = 0.
  - tlb_we = tlb_inv_valid = 0 immediately.
- Reset mid-op: the op is dropped with no TLB write/inv and no response.
- States: IDLE -> {SRCH, RD, WR, INV, RESP} -> RESP -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_* and all csr_* inputs; later CSR changes are ignored.
  - Next state follows the latched op: WR and FILL go to WR; illegal op goes directly to RESP with resp_err=1.
- SRCH (1 cycle):
  - tlb_s_vppn=csr_vppn, tlb_s_asid=csr_asid, tlb_s_va_bit12=0.
  - Register resp_found=tlb_s_found; resp_idx=tlb_s_index, or 0 on miss.
- RD (1 cycle):
  - tlb_r_index=csr_idx; register resp_* from tlb_r_*.
  - If r_e=0: resp_e=0 and all other RD fields 0.
- WR (1 cycle):
  - tlb_we=1; tlb_w_index = csr_idx (WR) or fill_cnt sampled at accept (FILL).
  - w_e = csr_tlbr ? 1 : ~csr_ne.
  - w_ps=csr_ps, w_vppn=csr_vppn, w_asid=csr_asid.
- INV (1 cycle):
  - If req_inv_op<=6: tlb_inv_valid=1, tlb_inv_op=req_inv_op, tlb_s_asid=req_inv_asid, tlb_s_vppn=va[31:13], tlb_s_va_bit12=va[12].
  - Else no strobe; resp_err=1.
- RESP:
  - resp_valid=1; held stable until resp_ready, then IDLE.
  - resp fields are stable while resp_valid=1.
  - Outputs not relevant to the op are 0; resp_err=0 unless set above.
- Strobes: tlb_we and tlb_inv_valid are high exactly one cycle per op, never outside WR/INV. Port-1 and read-port drive values are 0 outside SRCH/RD/INV.
- Latency: accept at edge T, op executes cycle T+1, resp_valid from T+2. Best-case throughput is one op per 3 cycles.
- fill_cnt: free-running, +1 every cycle, wraps TLBNUM-1 -> 0.

Test Plan:
- Reset then TLBWR (csr_idx=5, vppn=19'h1234, ps=12, ne=0, elo0.G=elo1.G=1): one-cycle tlb_we, w_index=5, w_e=1, w_g=1; resp_valid 2 cycles after accept, resp_err=0.
- TLBSRCH with tlb_s_found=1, tlb_s_index=9 -> resp_found=1, resp_idx=9. With found=0 -> resp_found=0, resp_idx=0.
- TLBRD idx 3: r_e=1 gives resp fields equal to r_*. r_e=0 gives resp_e=0 and all RD fields 0.
- TLBFILL with fill_cnt=15 at accept -> w_index=15; counter wraps to 0 next cycle. csr_tlbr=1, ne=1 -> w_e=1.
- INVTLB op 5, asid 10'h3, va 32'h0040_3000 -> tlb_inv_valid one cycle, tlb_s_vppn=19'h201, va_bit12=1. Op 7 -> no strobe, resp_err=1.
- resp_ready held low 4 cycles: resp stable and req_ready=0. resetn pulse during WR state: tlb_we drops immediately, no response.
